mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_if.sv | 23 ++
 rtl/mux_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/mux-control bundle for the round-robin mux arbiter
interface mux_rr_arbiter_if #(
    parameter int CNT_W = 4
);
    logic [3:0]       req;
    logic [3:0]       grant;
    logic [2:0]       choice;
    logic             ena;
    logic             switch;
    logic [CNT_W-1:0] hold_cnt;

    // Requester side: drives requests, observes the grant and mux controls
    modport master (
        output req,
        input  grant, choice, ena, switch, hold_cnt
    );

    // Arbiter side
    modport slave (
        input  req,
        output grant, choice, ena, switch, hold_cnt
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the 4-input datapath mux select/enable
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_last;       // current owner while in OWN, previous owner in IDLE
    logic [3:0]       r_grant;
    logic [2:0]       r_choice;
    logic             r_ena;
    logic             r_switch;
    logic [CNT_W-1:0] r_hold_cnt;

    state_t           w_state_nx;
    logic [1:0]       w_last_nx;
    logic [CNT_W-1:0] w_hold_nx;
    logic             w_switch_nx;
    logic [3:0]       w_grant_nx;
    logic [2:0]       w_choice_nx;
    logic [3:0]       w_others;
    logic [2:0]       w_arb_all;
    logic [2:0]       w_arb_oth;

    // Returns {found, index}: first set bit of req searching from last+1 and wrapping.
    // Iterating from the farthest candidate down lets the nearest one overwrite.
    function automatic logic [2:0] f_arb(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate winners: unrestricted, and with the current owner excluded
    always_comb begin
        w_others  = bus.req & ~(4'b0001 << r_last);
        w_arb_all = f_arb(bus.req, r_last);
        w_arb_oth = f_arb(w_others, r_last);
    end

    // Next-state and next-output decisions
    always_comb begin
        w_state_nx  = r_state;
        w_last_nx   = r_last;
        w_hold_nx   = r_hold_cnt;
        w_switch_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_all[2]) begin
                    w_state_nx  = OWN;
                    w_last_nx   = w_arb_all[1:0];
                    w_hold_nx   = C_ONE;
                    w_switch_nx = 1'b1;
                end
            end
            OWN: begin
                if (bus.req[r_last] && (r_hold_cnt < C_MAX_HOLD)) begin
                    w_hold_nx = r_hold_cnt + C_ONE;
                end else if (w_arb_oth[2]) begin
                    // release with others waiting, or hold limit reached: hand over without a gap
                    w_last_nx   = w_arb_oth[1:0];
                    w_hold_nx   = C_ONE;
                    w_switch_nx = 1'b1;
                end else if (!bus.req[r_last]) begin
                    w_state_nx = IDLE;
                    w_hold_nx  = '0;
                end
                // else: lone owner at the limit keeps the grant, counter saturated
            end
            default: begin
                w_state_nx = IDLE;
                w_hold_nx  = '0;
            end
        endcase
        w_grant_nx  = (w_state_nx == OWN) ? (4'b0001 << w_last_nx) : 4'b0000;
        w_choice_nx = (w_state_nx == OWN) ? ({1'b0, w_last_nx} + 3'd1) : 3'd0;
    end

    // State and registered mux controls; no combinational path from req to outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 2'd3;
            r_grant    <= 4'b0000;
            r_choice   <= 3'd0;
            r_ena      <= 1'b0;
            r_switch   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_last     <= w_last_nx;
            r_grant    <= w_grant_nx;
            r_choice   <= w_choice_nx;
            r_ena      <= (w_state_nx == OWN);
            r_switch   <= w_switch_nx;
            r_hold_cnt <= w_hold_nx;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.choice   = r_choice;
    assign bus.ena      = r_ena;
    assign bus.switch   = r_switch;
    assign bus.hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - randomized self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int MH    = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mux_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: owner index (-1 = none), cycles held, last owner, switch pulse
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 3;
    bit m_sw    = 1'b0;
    int n_sw    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int after, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (after + k) % 4;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic rn);
        int w;
        if (!rn) begin
            m_owner = -1; m_cnt = 0; m_last = 3; m_sw = 1'b0;
        end else if (m_owner < 0) begin
            w = pick(r, m_last, -1);
            m_sw = (w >= 0);
            if (w >= 0) begin
                m_owner = w; m_cnt = 1; m_last = w;
            end
        end else if (r[m_owner] && m_cnt < MH) begin
            m_cnt++; m_sw = 1'b0;
        end else begin
            w = pick(r, m_owner, m_owner);
            m_sw = 1'b0;
            if (w >= 0) begin
                m_owner = w; m_cnt = 1; m_last = w; m_sw = 1'b1;
            end else if (!r[m_owner]) begin
                m_owner = -1; m_cnt = 0;
            end
        end
    endfunction

    // Called at a falling edge: apply inputs, advance model over the rising edge, compare
    task automatic step(input logic [3:0] r, input logic rn);
        logic [3:0] eg;
        bus.req = r;
        rst_n   = rn;
        model_step(r, rn);
        @(negedge clk);
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant",    32'(bus.grant),    32'(eg));
        chk("choice",   32'(bus.choice),   32'(m_owner + 1));
        chk("ena",      32'(bus.ena),      32'(m_owner >= 0));
        chk("switch",   32'(bus.switch),   32'(m_sw));
        chk("hold_cnt", 32'(bus.hold_cnt), 32'(m_cnt));
        if (bus.switch) n_sw++;
    endtask

    logic [3:0] r_rand;

    initial begin
        bus.req = 4'b0000;
        rst_n   = 1'b0;
        @(negedge clk);

        // Reset then idle
        step(4'b0000, 1'b0);
        chk("reset_grant", 32'(bus.grant), 32'd0);
        n_sw = 0;
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1);
        chk("idle_no_switch", 32'(n_sw), 32'd0);

        // 1010 from reset: owner 1, then drop req[1] -> owner 3 with no gap
        step(4'b0000, 1'b0);
        step(4'b1010, 1'b1);
        chk("t2_grant", 32'(bus.grant), 32'b0010);
        chk("t2_choice", 32'(bus.choice), 32'd2);
        step(4'b1000, 1'b1);
        chk("t2_handover", 32'(bus.grant), 32'b1000);
        chk("t2_switch", 32'(bus.switch), 32'd1);

        // All requesting: rotation every MH cycles
        step(4'b0000, 1'b0);
        n_sw = 0;
        for (int i = 0; i < 4 * MH + 1; i++) step(4'b1111, 1'b1);
        chk("rot_final_owner", 32'(bus.grant), 32'b0001);
        chk("rot_switch_count", 32'(n_sw), 32'd5);

        // Lone requester 2 saturates, then requester 0 preempts
        step(4'b0000, 1'b0);
        n_sw = 0;
        for (int i = 0; i < 12; i++) step(4'b0100, 1'b1);
        chk("sat_hold", 32'(bus.hold_cnt), 32'(MH));
        chk("sat_switch_once", 32'(n_sw), 32'd1);
        step(4'b0101, 1'b1);
        chk("preempt_grant", 32'(bus.grant), 32'b0001);
        chk("preempt_switch", 32'(bus.switch), 32'd1);
        for (int i = 0; i < 7; i++) step(4'b0101, 1'b1);

        // Reset mid-grant, then recovery to owner 2
        step(4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1);
        chk("mid_hold3", 32'(bus.hold_cnt), 32'd3);
        step(4'b0100, 1'b0);
        chk("mid_reset_grant", 32'(bus.grant), 32'd0);
        step(4'b0100, 1'b1);
        chk("mid_recover", 32'(bus.grant), 32'b0100);

        // Lone requester 1 toggles: passes through IDLE
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        chk("toggle_idle", 32'(bus.grant), 32'd0);
        step(4'b0010, 1'b1);
        chk("toggle_regrant", 32'(bus.switch), 32'd1);

        // Randomized traffic with sticky requests and rare resets
        r_rand = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom);
            step(r_rand, ($urandom_range(0, 59) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
